// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 registered selector: default sizes,
// the mode encoding and the modulo-N pointer increment.
package mux_pkg;

   localparam int MUX_WIDTH_DEF = 32;
   localparam int MUX_N_DEF     = 4;

   typedef enum logic {
      MUX_SEL = 1'b0,
      MUX_RR  = 1'b1
   } mux_mode_e;

   // Explicit wrap so non-power-of-two channel counts cycle correctly.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found when
// searching from ptr upwards, modulo N.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   always_comb begin
      int best;
      int off;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      best    = N;
      off     = 0;
      // Distance of each channel from the pointer; the closest requester wins.
      for (int i = 0; i < N; i++) begin
         off = (i >= int'(ptr)) ? (i - int'(ptr)) : (i - int'(ptr) + N);
         if (req[i] && (off < best)) begin
            best    = off;
            gnt_idx = SEL_W'(i);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nt1_rr.sv
// N-to-1 registered selector with per-channel valid/ready, explicit select
// or round-robin; round-robin is built only when MUX_NT1_RR_EN is defined.
module mux_nt1_rr
   import mux_pkg::*;
#(
   parameter  int WIDTH = MUX_WIDTH_DEF,
   parameter  int N     = MUX_N_DEF,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_ch,
   input  logic               out_ready
);

   // Handshake: a channel transfers when in_valid[i] && in_ready[i]; the
   // output drains when out_valid && out_ready, and both may happen together.

   logic             w_load;
   logic             w_sel_vld;
   logic             w_gnt_vld;
   logic             w_xfer;
   logic [SEL_W-1:0] w_gnt_idx;
   logic [WIDTH-1:0] w_gnt_data;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_ch;

   assign w_load = !r_out_valid || out_ready;

   // An out-of-range sel matches no channel and therefore grants nothing.
   always_comb begin
      w_sel_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((sel == SEL_W'(i)) && in_valid[i]) w_sel_vld = 1'b1;
      end
   end

`ifdef MUX_NT1_RR_EN
   logic             w_rr_mode;
   logic             w_rr_vld;
   logic [SEL_W-1:0] w_rr_idx;
   logic [SEL_W-1:0] r_rr_ptr;

   rr_arbiter #(.N(N)) u_rr_arbiter (
      .req     (in_valid),
      .ptr     (r_rr_ptr),
      .gnt_idx (w_rr_idx),
      .gnt_vld (w_rr_vld)
   );

   assign w_rr_mode = (mux_mode_e'(mode) == MUX_RR);
   assign w_gnt_idx = w_rr_mode ? w_rr_idx : sel;
   assign w_gnt_vld = w_rr_mode ? w_rr_vld : w_sel_vld;

   // Pointer survives explicit-select periods; only round-robin wins move it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_xfer && w_rr_mode) begin
         r_rr_ptr <= SEL_W'(wrap_inc(int'(w_gnt_idx), N));
      end
   end
`else
   logic w_unused_mode;
   assign w_unused_mode = mode;
   assign w_gnt_idx     = sel;
   assign w_gnt_vld     = w_sel_vld;
`endif

   assign w_xfer = w_gnt_vld && w_load;

   always_comb begin
      in_ready   = '0;
      w_gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_gnt_idx == SEL_W'(i)) begin
            in_ready[i] = w_load && w_gnt_vld;
            w_gnt_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_gnt_data;
         r_out_ch    <= w_gnt_idx;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;

endmodule
